// File: rtl/morra_pkg.sv
`default_nettype none
// ============================================================================
// morra_pkg : move/result codes, FSM states and move helpers for morra_giocatori
// Revision  : 1.0
// ============================================================================
package morra_pkg;

  localparam logic [1:0] NESSUNA = 2'b00;
  localparam logic [1:0] SASSO   = 2'b01;
  localparam logic [1:0] CARTA   = 2'b10;
  localparam logic [1:0] FORBICE = 2'b11;

  localparam logic [1:0] NULLO    = 2'b00;
  localparam logic [1:0] PRIMO    = 2'b01;
  localparam logic [1:0] SECONDO  = 2'b10;
  localparam logic [1:0] PAREGGIO = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CONFIG = 2'd1,
    S_GIOCA  = 2'd2,
    S_FINE   = 2'd3
  } stato_t;

  function automatic logic [1:0] next_move(input logic [1:0] m);
    case (m)
      SASSO:   return CARTA;
      CARTA:   return FORBICE;
      default: return SASSO;
    endcase
  endfunction

  // Raw proposal 00 means sasso; a proposal equal to the forbidden move is bumped.
  function automatic logic [1:0] scegli(input logic [1:0] proposta, input logic [1:0] vietata);
    logic [1:0] m;
    m = (proposta == NESSUNA) ? SASSO : proposta;
    return (m == vietata) ? next_move(m) : m;
  endfunction

  function automatic logic [4:0] inc_sat(input logic [4:0] x);
    return (x == 5'd31) ? x : x + 5'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/morra_lfsr.sv
`default_nettype none
// ============================================================================
// morra_lfsr : 8-bit Galois LFSR with synchronous load and step enables
// Revision   : 1.0
// ============================================================================
module morra_lfsr #(
  parameter logic [7:0] RESET_VAL = 8'h01,
  parameter logic [7:0] TAPS      = 8'hB8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  logic [7:0] seed_i,
  input  logic       step_i,
  output logic [7:0] value_o
);

  logic [7:0] lfsr_q;
  logic [7:0] lfsr_d;

  always_comb begin
    lfsr_d = lfsr_q;
    if (load_i) begin
      lfsr_d = seed_i;
    end else if (step_i) begin
      lfsr_d = (lfsr_q >> 1) ^ (lfsr_q[0] ? TAPS : 8'h00);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= RESET_VAL;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign value_o = lfsr_q;

endmodule
`default_nettype wire

// File: rtl/morra_giocatori.sv
`default_nettype none
// ============================================================================
// morra_giocatori : two LFSR-driven morra players facing the referee, with score
// Revision        : 1.0
// ============================================================================
module morra_giocatori
  import morra_pkg::*;
#(
  parameter logic [7:0] SEED_DEFAULT = 8'h01,
  parameter int         MAX_EXTRA    = 15
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       avvia,
  input  logic [7:0] seme,
  input  logic [3:0] extra,
  input  logic [1:0] manche,
  input  logic [1:0] partita,
  output logic [1:0] primo,
  output logic [1:0] secondo,
  output logic       inizia,
  output logic [4:0] punti_primo,
  output logic [4:0] punti_secondo,
  output logic [1:0] vincitore,
  output logic       finito,
  output logic       occupato,
  output logic       errore
);

  localparam logic [4:0] TIMEOUT   = 5'(4 + MAX_EXTRA + 2);
  localparam logic [4:0] EXTRA_LIM = 5'(MAX_EXTRA);

  stato_t     stato_q, stato_d;
  logic [3:0] cfg_q, cfg_d;
  logic [1:0] vp_q, vp_d;
  logic [1:0] vs_q, vs_d;
  logic [4:0] pp_q, pp_d;
  logic [4:0] ps_q, ps_d;
  logic [4:0] round_q, round_d;
  logic [1:0] vinc_q, vinc_d;
  logic       err_q, err_d;

  logic       lfsr_load;
  logic       lfsr_step;
  logic [7:0] lfsr_seed;
  logic [7:0] lfsr_val;
  logic [1:0] mossa_p;
  logic [1:0] mossa_s;

  morra_lfsr #(
    .RESET_VAL(SEED_DEFAULT),
    .TAPS     (8'hB8)
  ) u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (lfsr_load),
    .seed_i (lfsr_seed),
    .step_i (lfsr_step),
    .value_o(lfsr_val)
  );

  assign lfsr_seed = (seme == 8'h00) ? SEED_DEFAULT : seme;
  assign mossa_p   = scegli(lfsr_val[1:0], vp_q);
  assign mossa_s   = scegli(lfsr_val[3:2], vs_q);

  always_comb begin
    stato_d   = stato_q;
    cfg_d     = cfg_q;
    vp_d      = vp_q;
    vs_d      = vs_q;
    pp_d      = pp_q;
    ps_d      = ps_q;
    round_d   = round_q;
    vinc_d    = vinc_q;
    err_d     = err_q;
    lfsr_load = 1'b0;
    lfsr_step = 1'b0;
    case (stato_q)
      S_IDLE, S_FINE: begin
        if (avvia) begin
          stato_d   = S_CONFIG;
          lfsr_load = 1'b1;
          cfg_d     = ({1'b0, extra} > EXTRA_LIM) ? EXTRA_LIM[3:0] : extra;
          vp_d      = NESSUNA;
          vs_d      = NESSUNA;
          pp_d      = 5'd0;
          ps_d      = 5'd0;
          round_d   = 5'd0;
          vinc_d    = NULLO;
          err_d     = 1'b0;
        end
      end
      S_CONFIG: stato_d = S_GIOCA;
      S_GIOCA: begin
        lfsr_step = 1'b1;
        round_d   = inc_sat(round_q);
        // A decided match wins over the round result sampled on the same edge.
        if (partita != NULLO) begin
          vinc_d  = partita;
          stato_d = S_FINE;
        end else if (manche == NULLO) begin
          err_d   = 1'b1;
          vinc_d  = NULLO;
          stato_d = S_FINE;
        end else begin
          case (manche)
            PRIMO: begin
              vp_d = mossa_p;
              vs_d = NESSUNA;
              pp_d = inc_sat(pp_q);
            end
            SECONDO: begin
              vs_d = mossa_s;
              vp_d = NESSUNA;
              ps_d = inc_sat(ps_q);
            end
            default: begin
              vp_d = NESSUNA;
              vs_d = NESSUNA;
            end
          endcase
          if (round_d >= TIMEOUT) begin
            err_d   = 1'b1;
            vinc_d  = NULLO;
            stato_d = S_FINE;
          end
        end
      end
      default: stato_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stato_q <= S_IDLE;
      cfg_q   <= 4'd0;
      vp_q    <= NESSUNA;
      vs_q    <= NESSUNA;
      pp_q    <= 5'd0;
      ps_q    <= 5'd0;
      round_q <= 5'd0;
      vinc_q  <= NULLO;
      err_q   <= 1'b0;
    end else begin
      stato_q <= stato_d;
      cfg_q   <= cfg_d;
      vp_q    <= vp_d;
      vs_q    <= vs_d;
      pp_q    <= pp_d;
      ps_q    <= ps_d;
      round_q <= round_d;
      vinc_q  <= vinc_d;
      err_q   <= err_d;
    end
  end

  assign primo         = (stato_q == S_CONFIG) ? cfg_q[3:2] :
                         (stato_q == S_GIOCA)  ? mossa_p    : NESSUNA;
  assign secondo       = (stato_q == S_CONFIG) ? cfg_q[1:0] :
                         (stato_q == S_GIOCA)  ? mossa_s    : NESSUNA;
  assign inizia        = (stato_q == S_CONFIG);
  assign occupato      = (stato_q == S_CONFIG) || (stato_q == S_GIOCA);
  assign finito        = (stato_q == S_FINE);
  assign punti_primo   = pp_q;
  assign punti_secondo = ps_q;
  assign vincitore     = vinc_q;
  assign errore        = err_q;

endmodule
`default_nettype wire

// File: tb/tb_morra_giocatori.sv
`default_nettype none
// ============================================================================
// tb_morra_giocatori : directed bench for morra_giocatori with hand-computed moves
// Revision           : 1.0
// ============================================================================
module tb_morra_giocatori;

  logic       clk;
  logic       rst_n;
  logic       avvia;
  logic [7:0] seme;
  logic [3:0] extra;
  logic [1:0] manche;
  logic [1:0] partita;
  logic [1:0] primo;
  logic [1:0] secondo;
  logic       inizia;
  logic [4:0] punti_primo;
  logic [4:0] punti_secondo;
  logic [1:0] vincitore;
  logic       finito;
  logic       occupato;
  logic       errore;

  int checks;
  int errors;

  morra_giocatori #(
    .SEED_DEFAULT(8'h01),
    .MAX_EXTRA   (15)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .avvia        (avvia),
    .seme         (seme),
    .extra        (extra),
    .manche       (manche),
    .partita      (partita),
    .primo        (primo),
    .secondo      (secondo),
    .inizia       (inizia),
    .punti_primo  (punti_primo),
    .punti_secondo(punti_secondo),
    .vincitore    (vincitore),
    .finito       (finito),
    .occupato     (occupato),
    .errore       (errore)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, ".primo"},    8'(primo),         8'h00);
    chk({tag, ".secondo"},  8'(secondo),       8'h00);
    chk({tag, ".inizia"},   8'(inizia),        8'h00);
    chk({tag, ".pp"},       8'(punti_primo),   8'h00);
    chk({tag, ".ps"},       8'(punti_secondo), 8'h00);
    chk({tag, ".vinc"},     8'(vincitore),     8'h00);
    chk({tag, ".finito"},   8'(finito),        8'h00);
    chk({tag, ".occupato"}, 8'(occupato),      8'h00);
    chk({tag, ".errore"},   8'(errore),        8'h00);
  endtask

  // Moves for seed 8'h01 with primo winning every round:
  // lfsr 01,B8,5C,2E,17 -> round 2 primo sasso is forbidden and bumps to carta.
  logic [1:0] exp_p [5] = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b11};
  logic [1:0] exp_s [5] = '{2'b01, 2'b10, 2'b11, 2'b11, 2'b01};

  initial begin
    checks  = 0;
    errors  = 0;
    rst_n   = 1'b0;
    avvia   = 1'b0;
    seme    = 8'h00;
    extra   = 4'd0;
    manche  = 2'b11;
    partita = 2'b00;
    #23;
    chk_idle_outputs("reset");
    rst_n = 1'b1;
    repeat (10) tick();
    chk_idle_outputs("idle10");

    // Match 1: default seed, primo wins four rounds, then partita=01.
    avvia = 1'b1; seme = 8'h00; extra = 4'b0110;
    tick();
    avvia = 1'b0;
    chk("m1.cfg.inizia",   8'(inizia),   8'h01);
    chk("m1.cfg.primo",    8'(primo),    8'h01);
    chk("m1.cfg.secondo",  8'(secondo),  8'h02);
    chk("m1.cfg.occupato", 8'(occupato), 8'h01);
    tick();
    chk("m1.inizia_off", 8'(inizia), 8'h00);
    manche = 2'b01;
    for (int r = 0; r < 5; r++) begin
      chk($sformatf("m1.r%0d.primo", r + 1),   8'(primo),       8'(exp_p[r]));
      chk($sformatf("m1.r%0d.secondo", r + 1), 8'(secondo),     8'(exp_s[r]));
      chk($sformatf("m1.r%0d.pp", r + 1),      8'(punti_primo), 8'(r));
      if (r == 4) partita = 2'b01;
      tick();
    end
    partita = 2'b00;
    chk("m1.end.pp",       8'(punti_primo),   8'h04);
    chk("m1.end.ps",       8'(punti_secondo), 8'h00);
    chk("m1.end.vinc",     8'(vincitore),     8'h01);
    chk("m1.end.finito",   8'(finito),        8'h01);
    chk("m1.end.occupato", 8'(occupato),      8'h00);
    chk("m1.end.errore",   8'(errore),        8'h00);
    chk("m1.end.primo",    8'(primo),         8'h00);

    // Match 2: seed 17. Forbice repeat is bumped, secondo rule, then manche=00.
    avvia = 1'b1; seme = 8'h17; extra = 4'd0;
    tick();
    avvia = 1'b0;
    chk("m2.cfg.primo",  8'(primo),       8'h00);
    chk("m2.cfg.pp",     8'(punti_primo), 8'h00);
    chk("m2.cfg.finito", 8'(finito),      8'h00);
    tick();
    chk("m2.r1.primo",   8'(primo),   8'h03);
    chk("m2.r1.secondo", 8'(secondo), 8'h01);
    manche = 2'b01;
    tick();
    chk("m2.r2.primo_bump", 8'(primo),   8'h01);
    chk("m2.r2.secondo",    8'(secondo), 8'h01);
    manche = 2'b10;
    tick();
    chk("m2.r3.primo_free",  8'(primo),         8'h01);
    chk("m2.r3.secondo_bump", 8'(secondo),      8'h02);
    chk("m2.r3.ps",          8'(punti_secondo), 8'h01);
    manche = 2'b00;
    tick();
    chk("m2.err.errore",   8'(errore),      8'h01);
    chk("m2.err.finito",   8'(finito),      8'h01);
    chk("m2.err.vinc",     8'(vincitore),   8'h00);
    chk("m2.err.pp",       8'(punti_primo), 8'h01);
    chk("m2.err.occupato", 8'(occupato),    8'h00);
    manche = 2'b11;
    repeat (2) tick();
    chk("m2.err.sticky", 8'(errore), 8'h01);

    // Match 3: draws only, timeout after 21 rounds.
    avvia = 1'b1; seme = 8'h00; extra = 4'hF;
    tick();
    avvia = 1'b0;
    chk("m3.cfg.errore_clr", 8'(errore),  8'h00);
    chk("m3.cfg.primo",      8'(primo),   8'h03);
    chk("m3.cfg.secondo",    8'(secondo), 8'h03);
    tick();
    repeat (20) tick();
    chk("m3.r21.occupato", 8'(occupato), 8'h01);
    chk("m3.r21.errore",   8'(errore),   8'h00);
    tick();
    chk("m3.to.errore", 8'(errore),        8'h01);
    chk("m3.to.finito", 8'(finito),        8'h01);
    chk("m3.to.vinc",   8'(vincitore),     8'h00);
    chk("m3.to.pp",     8'(punti_primo),   8'h00);
    chk("m3.to.ps",     8'(punti_secondo), 8'h00);

    // Match 4: asynchronous reset during round 3, then a clean restart.
    avvia = 1'b1; seme = 8'h00; extra = 4'b0110;
    tick();
    avvia = 1'b0;
    tick();
    manche = 2'b01;
    repeat (2) tick();
    chk("m4.r3.pp", 8'(punti_primo), 8'h02);
    #2;
    rst_n = 1'b0;
    #1;
    chk_idle_outputs("m4.rst");
    #2;
    rst_n = 1'b1;
    tick();
    chk("m4.post.occupato", 8'(occupato), 8'h00);
    avvia = 1'b1;
    tick();
    avvia = 1'b0;
    chk("m4.cfg.inizia", 8'(inizia),      8'h01);
    chk("m4.cfg.pp",     8'(punti_primo), 8'h00);
    tick();
    chk("m4.r1.primo",   8'(primo),   8'h01);
    chk("m4.r1.secondo", 8'(secondo), 8'h01);
    manche = 2'b10;
    tick();
    chk("m4.r2.pp",      8'(punti_primo),   8'h00);
    chk("m4.r2.ps",      8'(punti_secondo), 8'h01);
    chk("m4.r2.primo",   8'(primo),         8'h01);
    chk("m4.r2.secondo", 8'(secondo),       8'h02);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
